// File: rtl/imm_encoder_if.sv
// Request/result bundle for the rotated-immediate encoder.
// The master issues start/value; the slave returns status and the encoded operand.
interface imm_encoder_if;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        valid;
  logic [11:0] shift_operand;

  modport master (
    output start,
    output value,
    input  busy,
    input  done,
    input  valid,
    input  shift_operand
  );

  modport slave (
    input  start,
    input  value,
    output busy,
    output done,
    output valid,
    output shift_operand
  );
endinterface

// File: rtl/imm_encoder.sv
// Finds the canonical {rot, imm8} pair such that ror(imm8, 2*rot) reproduces a 32-bit constant,
// searching rotations in ascending order, one candidate per clock.
module imm_encoder (
  input  logic          clk,
  input  logic          rst,
  imm_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] value_r;
  logic [3:0]  rot_r;
  logic        busy_r;
  logic        done_r;
  logic        valid_r;
  logic [11:0] shift_operand_r;

  logic [31:0] rotated_s;
  logic        match_s;

  // Rotate-left via a doubled word so that a zero amount needs no special case.
  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] amt);
    logic [63:0] dbl;
    dbl = {x, x} << amt;
    return dbl[63:32];
  endfunction

  // Candidate for the current rotation: undo ror(imm8, 2k) and require the upper 24 bits to be clear.
  always_comb begin
    rotated_s = 32'h0000_0000;
    match_s   = 1'b0;
    if (state_r == SEARCH) begin
      rotated_s = rol32(value_r, {rot_r, 1'b0});
      match_s   = (rotated_s[31:8] == 24'h00_0000);
    end else begin
      rotated_s = 32'h0000_0000;
      match_s   = 1'b0;
    end
  end

  // Search sequencer with registered status and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      value_r         <= 32'h0000_0000;
      rot_r           <= 4'd0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      valid_r         <= 1'b0;
      shift_operand_r <= 12'h000;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            value_r <= bus.value;
            rot_r   <= 4'd0;
            busy_r  <= 1'b1;
            state_r <= SEARCH;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        SEARCH: begin
          if (match_s) begin
            shift_operand_r <= {rot_r, rotated_s[7:0]};
            valid_r         <= 1'b1;
            done_r          <= 1'b1;
            state_r         <= DONE;
          end else if (rot_r == 4'd15) begin
            // Exhausted every rotation: the constant has no immediate form.
            shift_operand_r <= 12'h000;
            valid_r         <= 1'b0;
            done_r          <= 1'b1;
            state_r         <= DONE;
          end else begin
            rot_r   <= rot_r + 4'd1;
            state_r <= SEARCH;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.valid         = valid_r;
  assign bus.shift_operand = shift_operand_r;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: table of constants with expected latency/encoding,
// a scoreboard queue, and hand-built sequences for busy-ignore and mid-search reset.
module tb_imm_encoder;

  logic clk;
  logic rst;

  imm_encoder_if bus ();

  imm_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] value;
    int          lat;
    logic        valid;
    logic [11:0] shop;
  } vec_t;

  vec_t vecs [11];
  vec_t sbq [$];
  vec_t last_exp;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive start for the edge E0, then scramble value to show it is latched only at acceptance.
  task automatic launch(input logic [31:0] v, input int lat, input logic vld, input logic [11:0] sop);
    vec_t e;
    e.value = v; e.lat = lat; e.valid = vld; e.shop = sop;
    sbq.push_back(e);
    bus.start = 1'b1;
    bus.value = v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.value = $urandom;
  endtask

  // Called 1 time unit after E0; counts edges until done and compares against the scoreboard head.
  task automatic wait_done();
    vec_t e;
    int   lat_n;
    bit   seen;
    bit   busy_ok;
    seen    = 1'b0;
    busy_ok = 1'b1;
    lat_n   = 0;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = sbq.pop_front();
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        seen  = 1'b1;
        lat_n = i;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("latency", lat_n, e.lat);
    check("busy_during", {31'd0, busy_ok}, 32'd1);
    check("busy_at_done", {31'd0, bus.busy}, 32'd1);
    check("valid", {31'd0, bus.valid}, {31'd0, e.valid});
    check("shift_operand", {20'd0, bus.shift_operand}, {20'd0, e.shop});
    last_exp = e;
  endtask

  // Done must be a single-cycle strobe, and the result must persist through IDLE.
  task automatic post_done();
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    check("busy_idle", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    check("hold_valid", {31'd0, bus.valid}, {31'd0, last_exp.valid});
    check("hold_shop", {20'd0, bus.shift_operand}, {20'd0, last_exp.shop});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_valid"}, {31'd0, bus.valid}, 32'd0);
    check({tag, "_shop"}, {20'd0, bus.shift_operand}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h0000_00FF, 1,  1'b1, 12'h0FF};
    vecs[1]  = '{32'hFF00_0000, 5,  1'b1, 12'h4FF};
    vecs[2]  = '{32'hF000_000F, 3,  1'b1, 12'h2FF};
    vecs[3]  = '{32'h0000_03FC, 16, 1'b1, 12'hFFF};
    vecs[4]  = '{32'h0000_0101, 16, 1'b0, 12'h000};
    vecs[5]  = '{32'h0000_0000, 1,  1'b1, 12'h000};
    vecs[6]  = '{32'h0000_0001, 1,  1'b1, 12'h001};
    vecs[7]  = '{32'h0000_0100, 13, 1'b1, 12'hC01};
    vecs[8]  = '{32'h8000_0000, 2,  1'b1, 12'h102};
    vecs[9]  = '{32'hFFFF_FFFF, 16, 1'b0, 12'h000};
    vecs[10] = '{32'h3FC0_0000, 6,  1'b1, 12'h5FF};

    bus.start = 1'b0;
    bus.value = 32'h0000_0000;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // First edge after reset release must accept the request.
    launch(vecs[0].value, vecs[0].lat, vecs[0].valid, vecs[0].shop);
    wait_done();
    post_done();

    for (int i = 1; i < 11; i++) begin
      launch(vecs[i].value, vecs[i].lat, vecs[i].valid, vecs[i].shop);
      wait_done();
      post_done();
    end

    // Start re-pulsed during SEARCH and during DONE must be ignored.
    launch(32'hFF00_0000, 5, 1'b1, 12'h4FF);
    fork
      begin
        @(posedge clk);
        @(posedge clk);
        #2;
        bus.start = 1'b1;
        bus.value = 32'h0000_00FF;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
      end
    join_none
    wait_done();
    bus.start = 1'b1;
    bus.value = 32'h0000_0001;
    @(posedge clk);
    #1;
    check("ign_done_busy", {31'd0, bus.busy}, 32'd0);
    check("ign_done_strobe", {31'd0, bus.done}, 32'd0);
    check("ign_done_shop", {20'd0, bus.shift_operand}, 32'h4FF);
    // Still asserted in IDLE with a new value: this one is accepted.
    launch(32'h0000_0100, 13, 1'b1, 12'hC01);
    wait_done();
    post_done();

    // Reset while k=7 is being tested aborts the search with no done strobe.
    launch(32'h0000_0101, 16, 1'b0, 12'h000);
    void'(sbq.pop_back());
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    begin
      bit strobe;
      strobe = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk);
        #1;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) strobe = 1'b1;
      end
      check("no_done_after_abort", {31'd0, strobe}, 32'd0);
    end
    launch(32'h0000_0000, 1, 1'b1, 12'h000);
    wait_done();
    post_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
